// File: rtl/cm_input_debouncer.sv
// Input conditioning for the two custom_matrix lanes: 2-flop synchroniser on the raw pad bus,
// then an independent STABLE/SETTLE debounce FSM per 4-bit lane with a commit strobe.
module cm_input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] raw_in,
    output logic [7:0] code_out,
    output logic [1:0] code_valid,
    output logic [1:0] lane_busy
);

    localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_SETTLE = 1'b1
    } lane_state_t;

    logic [7:0] r_sync1;
    logic [7:0] r_sync2;

    // The first stage may go metastable, so only the second stage feeds any logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [3:0]       w_s;
        lane_state_t      r_state;
        logic [3:0]       r_cand;
        logic [3:0]       r_code;
        logic [CNT_W-1:0] r_cnt;
        logic             r_valid;

        assign w_s = r_sync2[g*4 +: 4];

        // The candidate must be seen DEBOUNCE_CYCLES times in a row; cnt counts the ones already seen.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_STABLE;
                r_cand  <= '0;
                r_code  <= '0;
                r_cnt   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= 1'b0;
                if (ena) begin
                    if (r_state == ST_STABLE) begin
                        if (w_s != r_code) begin
                            r_state <= ST_SETTLE;
                            r_cand  <= w_s;
                            r_cnt   <= LP_CNT_ONE;
                        end
                    end else if (w_s == r_cand) begin
                        if (r_cnt == LP_CNT_LAST) begin
                            r_code  <= r_cand;
                            r_valid <= 1'b1;
                            r_state <= ST_STABLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + LP_CNT_ONE;
                        end
                    end else if (w_s == r_code) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cand <= w_s;
                        r_cnt  <= LP_CNT_ONE;
                    end
                end
            end
        end

        assign code_out[g*4 +: 4] = r_code;
        assign code_valid[g]      = r_valid;
        assign lane_busy[g]       = (r_state == ST_SETTLE);
    end

endmodule
